// File: rtl/mips_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit state).
package mips_uart_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam int unsigned BUSY = 0;
  localparam int unsigned FULL = 1;
  localparam int unsigned OVF  = 2;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;
`else
  localparam int unsigned ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

  // Even parity of a data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mips_uart_tx_mmio_fifo.sv
// Byte FIFO with first-word fall-through read port for the UART transmitter.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop)  r_rd <= r_rd + AW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/mips_uart_tx_mmio.sv
// Memory-mapped UART transmitter on the MIPS data bus: decode, status, FIFO and 8N1 serialiser.
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit between data and stop).
module mips_uart_tx_mmio
  import mips_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        tx,
  output logic        tx_busy
);

  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  tx_state_e   r_state;
  logic        r_tx;
  logic [7:0]  r_shift;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic        r_ovf;
  logic        r_par;

  tx_state_e   w_state_nxt;
  logic        w_tx_nxt;
  logic [7:0]  w_shift_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_par_nxt;

  logic [3:0]  w_ofs;
  logic        w_push_req;
  logic        w_fifo_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_dout;
  logic        w_bit_end;
  logic [31:0] w_status;
  logic        w_unused;

  // Address decode and register strobes
  assign w_ofs       = Addr[3:0];
  assign Sel         = (Addr[31:4] == BASE_ADDR[31:4]);
  assign w_push_req  = Sel & MemWrite & (w_ofs == TXDATA_OFS);
  assign w_ovf_clr   = Sel & MemWrite & (w_ofs == STATUS_OFS) & WriteData[OVF];
  // A full FIFO still takes the byte when the serialiser pops in the same cycle.
  assign w_fifo_push = w_push_req & (~w_full | w_pop);
  assign w_ovf_set   = w_push_req & w_full & ~w_pop;
  assign w_bit_end   = (r_cnt == BIT_LAST);
  assign tx_busy     = (r_state != ST_IDLE) | ~w_empty;
  assign tx          = r_tx;
  assign w_unused    = ^WriteData[31:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .pop   (w_pop),
    .din   (WriteData[7:0]),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  // STATUS word and read mux
  always_comb begin
    w_status      = '0;
    w_status[BUSY] = tx_busy;
    w_status[FULL] = w_full;
    w_status[OVF]  = r_ovf;
    ReadData      = '0;
    if (Sel && (w_ofs == STATUS_OFS)) ReadData = w_status;
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // Serialiser next-state: frame sequencing, bit timing and FIFO pops
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    w_par_nxt   = r_par;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = r_par;
            w_state_nxt = ST_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_idx_nxt   = r_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      w_shift_nxt = w_dout;
      w_par_nxt   = even_parity(w_dout);
    end
  end

  // Serialiser state register; reset forces the line idle high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_par   <= w_par_nxt;
    end
  end

endmodule

// File: tb/tb_mips_uart_tx_mmio.sv
// Self-checking bench for mips_uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
module tb_mips_uart_tx_mmio;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME = NSLOT * D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Addr = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Sel;
  logic        tx;
  logic        tx_busy;

  mips_uart_tx_mmio #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .MemWrite(MemWrite), .WriteData(WriteData),
    .ReadData(ReadData), .Sel(Sel), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame currently on the wire, tracked as a cycle position.
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (NSLOT == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [10:0] frame_vec(input logic [7:0] b);
    logic [10:0] v = '0;
    for (int s = 0; s < NSLOT; s++) v[s] = frame_bit(b, s);
    return v;
  endfunction

  function automatic bit m_sel(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == (BASE & 32'hFFFF_FFF0);
  endfunction

  function automatic logic m_tx();
    return m_active ? frame_bit(m_cur, m_pos / D) : 1'b1;
  endfunction

  function automatic logic m_busy();
    return m_active || (m_q.size() != 0);
  endfunction

  function automatic logic [31:0] m_status();
    return {29'b0, m_ovf, (m_q.size() == DEPTH), m_busy()};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_pos    = 0;
    m_cur    = '0;
    m_ovf    = 0;
  endtask

  task automatic model_step();
    bit push, clr, pop;
    logic [3:0] ofs;
    ofs  = Addr[3:0];
    push = m_sel(Addr) && MemWrite && (ofs == 4'h0);
    clr  = m_sel(Addr) && MemWrite && (ofs == 4'h4) && WriteData[2];
    pop  = (!m_active || m_pos == FRAME - 1) && (m_q.size() != 0);
    if (pop) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_pos    = 0;
    end else if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 0;
      else m_pos++;
    end
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
      else m_ovf = 1;
    end else if (clr) begin
      m_ovf = 0;
    end
  endtask

  logic       cap_q[$];
  bit         capturing = 0;
  logic [7:0] exp_bytes[$];

  // One clock edge: advance the model, then compare the registered outputs.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    cyc++;
    #1;
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("tx_busy", 32'(tx_busy), 32'(m_busy()));
    if (capturing) cap_q.push_back(tx);
  endtask

  // Apply bus inputs and compare the combinational decode outputs.
  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd);
    Addr      = a;
    MemWrite  = we;
    WriteData = wd;
    #1;
    chk("Sel", 32'(Sel), 32'(m_sel(a)));
    chk("ReadData", ReadData, (m_sel(a) && a[3:0] == 4'h4) ? m_status() : 32'h0);
  endtask

  task automatic check_frames(input string name);
    for (int f = 0; f < exp_bytes.size(); f++) begin
      logic [10:0] act = '0;
      bit stable = 1;
      for (int s = 0; s < NSLOT; s++) begin
        int first = f * FRAME + s * D;
        for (int k = 0; k < D; k++) begin
          if (first + k >= cap_q.size()) stable = 0;
          else if (cap_q[first + k] !== cap_q[first]) stable = 0;
        end
        if (first + D / 2 < cap_q.size()) act[s] = cap_q[first + D / 2];
      end
      chk($sformatf("%s_frame%0d", name, f), 32'(act), 32'(frame_vec(exp_bytes[f])));
      chk($sformatf("%s_stable%0d", name, f), 32'(stable), 32'd1);
    end
  endtask

  task automatic send_one(input logic [7:0] b, input string name);
    int n0;
    drive(BASE, 1'b1, {24'hC0FFEE, b});
    cycle();
    n0 = cyc;
    cap_q.delete();
    capturing = 1;
    drive(BASE + 32'h4, 1'b0, 32'h0);
    while (cyc < n0 + FRAME) cycle();
    chk({name, "_busy_last"}, 32'(tx_busy), 32'd1);
    cycle();
    chk({name, "_busy_end"}, 32'(tx_busy), 32'd0);
    capturing = 0;
    exp_bytes.delete();
    exp_bytes.push_back(b);
    check_frames(name);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int lows;
    logic [7:0] ob[6];

    // Reset state
    model_reset();
    Addr = BASE + 32'h4;
    repeat (3) cycle();
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_status", ReadData, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Decode table on an idle block
    vt[0] = '{BASE,                1'b0, 32'h0,  1'b1, 32'h0};
    vt[1] = '{BASE + 32'h4,        1'b0, 32'h0,  1'b1, 32'h0};
    vt[2] = '{BASE + 32'h8,        1'b0, 32'h0,  1'b1, 32'h0};
    vt[3] = '{BASE + 32'hC,        1'b0, 32'h0,  1'b1, 32'h0};
    vt[4] = '{BASE + 32'h3,        1'b0, 32'h0,  1'b1, 32'h0};
    vt[5] = '{32'hFFFE_0004,       1'b0, 32'h0,  1'b0, 32'h0};
    vt[6] = '{32'h0000_0004,       1'b0, 32'h0,  1'b0, 32'h0};
    vt[7] = '{32'hFFFF_0014,       1'b0, 32'h0,  1'b0, 32'h0};
    vt[8] = '{BASE + 32'h8,        1'b1, 32'hFF, 1'b1, 32'h0};
    vt[9] = '{BASE + 32'h4,        1'b1, 32'h4,  1'b1, 32'h0};
    for (int i = 0; i < 10; i++) begin
      Addr      = vt[i].addr;
      MemWrite  = vt[i].we;
      WriteData = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_sel", i), 32'(Sel), 32'(vt[i].exp_sel));
      chk($sformatf("vec%0d_rd", i), ReadData, vt[i].exp_rd);
      cycle();
    end
    drive(BASE + 32'h4, 1'b0, 32'h0);
    chk("ignored_writes_status", ReadData, 32'h0);

    // Single byte
    send_one(8'h55, "single55");

    // Back-to-back frames, no idle gap
    drive(BASE, 1'b1, 32'h0000_00A5);
    cycle();
    n0 = cyc;
    cap_q.delete();
    capturing = 1;
    drive(BASE, 1'b1, 32'h0000_003C);
    cycle();
    drive(BASE + 32'h4, 1'b0, 32'h0);
    while (cyc < n0 + 2 * FRAME) cycle();
    chk("b2b_busy_last", 32'(tx_busy), 32'd1);
    cycle();
    chk("b2b_busy_end", 32'(tx_busy), 32'd0);
    capturing = 0;
    exp_bytes.delete();
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h3C);
    check_frames("b2b");

    // Overflow: six consecutive stores into a depth-4 FIFO
    for (int i = 0; i < 6; i++) ob[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      drive(BASE, 1'b1, {24'h0, ob[i]});
      cycle();
      if (i == 0) begin
        n0 = cyc;
        cap_q.delete();
        capturing = 1;
      end
    end
    drive(BASE + 32'h4, 1'b0, 32'h0);
    chk("ovf_status", ReadData, 32'h7);
    drive(BASE + 32'h4, 1'b1, 32'h4);
    chk("ovf_status_before_clear", ReadData, 32'h7);
    cycle();
    drive(BASE + 32'h4, 1'b0, 32'h0);
    chk("ovf_status_cleared", ReadData, 32'h3);
    while (cyc < n0 + 5 * FRAME) cycle();
    chk("ovf_busy_last", 32'(tx_busy), 32'd1);
    cycle();
    chk("ovf_busy_end", 32'(tx_busy), 32'd0);
    capturing = 0;
    exp_bytes.delete();
    for (int i = 0; i < 5; i++) exp_bytes.push_back(ob[i]);
    check_frames("ovf");

    // Asynchronous reset during data bit 3 of 0xFF, with another byte queued
    drive(BASE, 1'b1, 32'h0000_00FF);
    cycle();
    n0 = cyc;
    drive(BASE, 1'b1, 32'h0000_0000);
    cycle();
    drive(BASE + 32'h4, 1'b0, 32'h0);
    while (cyc < n0 + 1 + 4 * D + 1) cycle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(tx_busy), 32'd0);
    chk("arst_status", ReadData, 32'h0);
    repeat (2) cycle();
    @(negedge clk);
    rst = 1'b1;
    lows = 0;
    repeat (3 * FRAME) begin
      cycle();
      if (tx !== 1'b1) lows++;
    end
    chk("arst_no_residual", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Even parity bit
    send_one(8'h07, "par07");
    chk("par07_bit", 32'(cap_q[9 * D + D / 2]), 32'd1);
    send_one(8'h03, "par03");
    chk("par03_bit", 32'(cap_q[9 * D + D / 2]), 32'd0);
`endif

    // Randomized bus traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 9)       drive(BASE, 1'b1, $urandom);
      else if (r < 12) drive(BASE + 32'h4, 1'b1, $urandom);
      else if (r < 14) drive(BASE + 32'($urandom_range(8, 15)), 1'b1, $urandom);
      else if (r < 20) drive($urandom, 1'($urandom_range(0, 1)), $urandom);
      else             drive(BASE + 32'h4, 1'b0, 32'h0);
      cycle();
    end
    drive(BASE + 32'h4, 1'b0, 32'h0);
    repeat ((DEPTH + 2) * FRAME) cycle();
    chk("drain_busy", 32'(tx_busy), 32'd0);
    chk("drain_tx", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
